// File: rtl/bus_arb_pkg.sv
// Shared FSM encoding, defaults and helpers for the split-transaction bus arbiter.
package bus_arb_pkg;

    localparam int unsigned StateW               = 2;
    localparam int unsigned DefaultTimeoutCycles = 1024;

    typedef enum logic [StateW-1:0] {
        StIdle    = 2'd0,
        StMGrant  = 2'd1,
        StSGrant  = 2'd2,
        StRelease = 2'd3
    } arb_state_e;

    // Index of the (single) set bit; returns 0 for an all-zero vector.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer, wrapping.
module rr_arbiter #(
    parameter int unsigned NumReq = 2,
    parameter int unsigned PtrW   = 1
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [PtrW-1:0]   ptr_i,
    output logic [NumReq-1:0] gnt_o,
    output logic              valid_o
);

    logic [NumReq-1:0] low_mask;
    logic [NumReq-1:0] upper_req;

    always_comb begin
        low_mask  = (NumReq'(1) << ptr_i) - NumReq'(1);
        upper_req = req_i & ~low_mask;
        // x & -x isolates the lowest set bit; fall back to the wrapped search.
        if (|upper_req) begin
            gnt_o = upper_req & (~upper_req + NumReq'(1));
        end else begin
            gnt_o = req_i & (~req_i + NumReq'(1));
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with split-transaction resume, tenure timeout and
// an end-of-tenure utilisation pulse.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 2,
    parameter int unsigned NUM_SLAVES     = 3,
    parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles,
    parameter int unsigned MID_WIDTH      = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] mstr_req,
    input  logic [NUM_MASTERS-1:0] mstr_done,
    input  logic [NUM_SLAVES-1:0]  slv_busy,
    input  logic [NUM_SLAVES-1:0]  slv_done,
    output logic [NUM_MASTERS-1:0] mstr_grant,
    output logic [NUM_SLAVES-1:0]  slv_cmd,
    output logic                   bus_util,
    output logic                   timeout_err,
    output logic [StateW-1:0]      state_out
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    arb_state_e                           state_q, state_d;
    logic [NUM_MASTERS-1:0]               grant_q, grant_d;
    logic [NUM_SLAVES-1:0]                cmd_q, cmd_d;
    logic                                 util_q, util_d;
    logic                                 terr_q, terr_d;
    logic [MID_WIDTH-1:0]                 ptr_q, ptr_d;
    logic [NUM_SLAVES-1:0]                pend_q, pend_d;
    logic [NUM_SLAVES-1:0][MID_WIDTH-1:0] owner_q, owner_d;
    logic [NUM_SLAVES-1:0]                busy_prev_q;
    logic [CntW-1:0]                      cnt_q, cnt_d;

    logic [NUM_MASTERS-1:0] rr_gnt;
    logic                   rr_valid;
    logic [MID_WIDTH-1:0]   rr_idx, ptr_next, cur_mid, owner_sel;
    logic [NUM_SLAVES-1:0]  busy_rise, slv_cand, slv_pick;
    logic                   mst_done_hit, slv_done_hit, tmo_hit;

    rr_arbiter #(
        .NumReq (NUM_MASTERS),
        .PtrW   (MID_WIDTH)
    ) u_mstr_rr (
        .req_i   (mstr_req),
        .ptr_i   (ptr_q),
        .gnt_o   (rr_gnt),
        .valid_o (rr_valid)
    );

    assign rr_idx       = MID_WIDTH'(onehot_to_idx(8'(rr_gnt)));
    assign ptr_next     = (rr_idx == MID_WIDTH'(NUM_MASTERS - 1)) ? '0 : rr_idx + MID_WIDTH'(1);
    assign cur_mid      = MID_WIDTH'(onehot_to_idx(8'(grant_q)));
    assign busy_rise    = slv_busy & ~busy_prev_q;
    assign slv_cand     = pend_q & ~slv_busy;
    assign slv_pick     = slv_cand & (~slv_cand + NUM_SLAVES'(1));
    assign mst_done_hit = |(mstr_done & grant_q);
    assign slv_done_hit = |(slv_done & cmd_q);
    assign tmo_hit      = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        owner_sel = '0;
        for (int s = 0; s < NUM_SLAVES; s++) begin
            if (slv_pick[s]) begin
                owner_sel = owner_q[s];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cmd_d   = cmd_q;
        util_d  = 1'b0;
        terr_d  = 1'b0;
        ptr_d   = ptr_q;
        pend_d  = pend_q;
        owner_d = owner_q;
        cnt_d   = '0;

        // A slave going busy under a master tenure parks that master's transfer.
        if (state_q == StMGrant) begin
            for (int s = 0; s < NUM_SLAVES; s++) begin
                if (busy_rise[s]) begin
                    pend_d[s]  = 1'b1;
                    owner_d[s] = cur_mid;
                end
            end
        end

        unique case (state_q)
            StIdle: begin
                if (|slv_pick) begin
                    state_d = StSGrant;
                    cmd_d   = slv_pick;
                    grant_d = NUM_MASTERS'(1) << owner_sel;
                end else if (rr_valid) begin
                    state_d = StMGrant;
                    grant_d = rr_gnt;
                    ptr_d   = ptr_next;
                end
            end
            StMGrant: begin
                if (mst_done_hit || tmo_hit) begin
                    state_d = StRelease;
                    grant_d = '0;
                    util_d  = 1'b1;
                    terr_d  = ~mst_done_hit;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StSGrant: begin
                if (slv_done_hit || tmo_hit) begin
                    state_d = StRelease;
                    pend_d  = pend_d & ~cmd_q;
                    grant_d = '0;
                    cmd_d   = '0;
                    util_d  = 1'b1;
                    terr_d  = ~slv_done_hit;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StRelease: begin
                state_d = StIdle;
                grant_d = '0;
                cmd_d   = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            cmd_q       <= '0;
            util_q      <= 1'b0;
            terr_q      <= 1'b0;
            ptr_q       <= '0;
            pend_q      <= '0;
            owner_q     <= '0;
            busy_prev_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            cmd_q       <= cmd_d;
            util_q      <= util_d;
            terr_q      <= terr_d;
            ptr_q       <= ptr_d;
            pend_q      <= pend_d;
            owner_q     <= owner_d;
            busy_prev_q <= slv_busy;
            cnt_q       <= cnt_d;
        end
    end

    assign mstr_grant  = grant_q;
    assign slv_cmd     = cmd_q;
    assign bus_util    = util_q;
    assign timeout_err = terr_q;
    assign state_out   = state_q;

endmodule
